// File: rtl/noc_pkg.sv
// Shared packet layout, FSM state types and packing helper for the mesh PE network interface.
package noc_pkg;

  localparam int unsigned WIDTH    = 35;
  localparam int unsigned DEST_MSB = 34;
  localparam int unsigned DEST_LSB = 31;
  localparam int unsigned SRC_MSB  = 30;
  localparam int unsigned SRC_LSB  = 27;
  localparam int unsigned TYPE_MSB = 26;
  localparam int unsigned TYPE_LSB = 24;
  localparam int unsigned PAY_MSB  = 23;
  localparam int unsigned PAY_LSB  = 0;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [2:0]  ptype;
    logic [23:0] payload;
  } packet_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT_ACK_HI,
    TX_WAIT_ACK_LO
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACK_HI
  } rx_state_t;

  function automatic packet_t pack_pkt(input logic [3:0]  dest,
                                       input logic [3:0]  src,
                                       input logic [2:0]  ptype,
                                       input logic [23:0] payload);
    packet_t p;
    p.dest    = dest;
    p.src     = src;
    p.ptype   = ptype;
    p.payload = payload;
    return p;
  endfunction

endpackage

// File: rtl/noc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous handshake bit, cleared by synchronous reset.
module noc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_stages_chk
    $error("noc_sync_bit: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/noc_pe_net_interface.sv
// PE <-> mesh router endpoint: 4-phase bundled-data TX packer and RX unpacker with FWFT buffer.
module noc_pe_net_interface #(
  parameter int unsigned WIDTH       = 35,
  parameter int unsigned NODE_ID     = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [3:0]       tx_dest,
  input  logic [2:0]       tx_type,
  input  logic [23:0]      tx_payload,
  output logic             net_out_req,
  output logic [WIDTH-1:0] net_out_data,
  input  logic             net_out_ack,
  input  logic             net_in_req,
  input  logic [WIDTH-1:0] net_in_data,
  output logic             net_in_ack,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [3:0]       rx_src,
  output logic [2:0]       rx_type,
  output logic [23:0]      rx_payload,
  output logic [7:0]       misroute_cnt
);

  import noc_pkg::*;

  if (WIDTH != noc_pkg::WIDTH) begin : g_width_chk
    $error("noc_pe_net_interface: WIDTH must be 35");
  end
  if (NODE_ID > 15) begin : g_node_chk
    $error("noc_pe_net_interface: NODE_ID must be 0..15");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("noc_pe_net_interface: FIFO_DEPTH must be a power of 2 in 2..16");
  end

  localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0]     NODE    = 4'(NODE_ID);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic ack_sync, req_sync;

  noc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .reset (reset),
    .d     (net_out_ack),
    .q     (ack_sync)
  );

  noc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .reset (reset),
    .d     (net_in_req),
    .q     (req_sync)
  );

  tx_state_t tx_state_q, tx_state_d;
  logic      tx_ready_q, tx_ready_d;
  logic      out_req_q, out_req_d;
  packet_t   out_data_q, out_data_d;

  always_comb begin
    tx_state_d = tx_state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          out_data_d = pack_pkt(tx_dest, NODE, tx_type, tx_payload);
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        out_req_d  = 1'b1;
        tx_state_d = TX_WAIT_ACK_HI;
      end
      TX_WAIT_ACK_HI: begin
        if (ack_sync) begin
          out_req_d  = 1'b0;
          tx_state_d = TX_WAIT_ACK_LO;
        end
      end
      TX_WAIT_ACK_LO: begin
        if (!ack_sync) tx_state_d = TX_IDLE;
      end
    endcase
    // Ready is withheld while a stale ack (e.g. after reset mid-handshake) is still visible.
    tx_ready_d = (tx_state_d == TX_IDLE) && !ack_sync;
  end

  rx_state_t        rx_state_q, rx_state_d;
  logic             in_ack_q, in_ack_d;
  logic [7:0]       mis_q, mis_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [SRC_MSB:0] fifo_mem [FIFO_DEPTH];
  logic [SRC_MSB:0] head;

  always_comb begin
    rx_state_d = rx_state_q;
    in_ack_d   = in_ack_q;
    mis_d      = mis_q;
    push       = 1'b0;
    pop        = (count_q != '0) && rx_ready;
    unique case (rx_state_q)
      RX_IDLE: begin
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        if (req_sync && (count_q != DEPTH_C || pop)) begin
          in_ack_d   = 1'b1;
          rx_state_d = RX_ACK_HI;
          if (net_in_data[DEST_MSB:DEST_LSB] == NODE) push = 1'b1;
          else if (mis_q != 8'hFF)                     mis_d = mis_q + 8'd1;
        end
      end
      RX_ACK_HI: begin
        if (!req_sync) begin
          in_ack_d   = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end
    endcase
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_ready_q <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      rx_state_q <= RX_IDLE;
      in_ack_q   <= 1'b0;
      mis_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_ready_q <= tx_ready_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      rx_state_q <= rx_state_d;
      in_ack_q   <= in_ack_d;
      mis_q      <= mis_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= net_in_data[SRC_MSB:0];
  end

  assign head         = fifo_mem[rd_ptr_q];
  assign tx_ready     = tx_ready_q;
  assign net_out_req  = out_req_q;
  assign net_out_data = out_data_q;
  assign net_in_ack   = in_ack_q;
  assign misroute_cnt = mis_q;
  assign rx_valid     = (count_q != '0);
  assign rx_src       = rx_valid ? head[SRC_MSB:SRC_LSB]   : '0;
  assign rx_type      = rx_valid ? head[TYPE_MSB:TYPE_LSB] : '0;
  assign rx_payload   = rx_valid ? head[PAY_MSB:PAY_LSB]   : '0;

endmodule

// File: tb/tb_noc_pe_net_interface.sv
// Self-checking bench: router-side handshake emulation, directed corner cases and randomized traffic.
module tb_noc_pe_net_interface;

  localparam int unsigned SS   = 2;
  localparam logic [3:0]  NODE = 4'd5;

  logic        clk, reset;
  logic        tx_valid, tx_ready;
  logic [3:0]  tx_dest;
  logic [2:0]  tx_type;
  logic [23:0] tx_payload;
  logic        net_out_req, net_out_ack;
  logic [34:0] net_out_data;
  logic        net_in_req, net_in_ack;
  logic [34:0] net_in_data;
  logic        rx_valid, rx_ready;
  logic [3:0]  rx_src;
  logic [2:0]  rx_type;
  logic [23:0] rx_payload;
  logic [7:0]  misroute_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned mis_exp = 0;
  bit          rx_done;
  logic [34:0] rx_exp_q[$];

  noc_pe_net_interface #(
    .WIDTH       (35),
    .NODE_ID     (5),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_dest      (tx_dest),
    .tx_type      (tx_type),
    .tx_payload   (tx_payload),
    .net_out_req  (net_out_req),
    .net_out_data (net_out_data),
    .net_out_ack  (net_out_ack),
    .net_in_req   (net_in_req),
    .net_in_data  (net_in_data),
    .net_in_ack   (net_in_ack),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_src       (rx_src),
    .rx_type      (rx_type),
    .rx_payload   (rx_payload),
    .misroute_cnt (misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  typedef struct {
    logic [3:0]  dest;
    logic [2:0]  ptype;
    logic [23:0] payload;
    logic [34:0] exp_data;
  } tx_vec_t;

  tx_vec_t tx_vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat255(input int unsigned n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  // Router PE_in side: responds to one TX packet, checking the 4-phase timing as it goes.
  task automatic tx_send(input logic [3:0] d, input logic [2:0] t, input logic [23:0] p,
                         input logic [34:0] exp_data, input int unsigned ack_dly);
    int unsigned n;
    tx_dest = d; tx_type = t; tx_payload = p; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin tick(); n++; end
    check("tx_ready_wait", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    tx_dest = 4'($urandom); tx_type = 3'($urandom); tx_payload = 24'($urandom);
    check("tx_data", net_out_data, exp_data);
    check("tx_req_after_data", net_out_req, 0);
    tick();
    check("tx_req_rise", net_out_req, 1);
    check("tx_ready_busy", tx_ready, 0);
    repeat (ack_dly) tick();
    check("tx_req_hold", net_out_req, 1);
    net_out_ack = 1'b1;
    repeat (SS) tick();
    check("tx_req_before_sync", net_out_req, 1);
    tick();
    check("tx_req_fall", net_out_req, 0);
    check("tx_data_hold", net_out_data, exp_data);
    net_out_ack = 1'b0;
    repeat (SS) tick();
    check("tx_ready_ack_lo", tx_ready, 0);
    tick();
    check("tx_ready_back", tx_ready, 1);
  endtask

  // Router PE_out side: present data, then raise req one cycle later.
  task automatic rx_start(input logic [34:0] pkt);
    net_in_data = pkt;
    if (pkt[34:31] == NODE) rx_exp_q.push_back(pkt);
    else mis_exp++;
    tick();
    net_in_req = 1'b1;
  endtask

  task automatic rx_finish(input int exact_lat, input int unsigned hold);
    int unsigned n;
    n = 0;
    while (!net_in_ack && n < 2000) begin tick(); n++; end
    check("rx_ack_rise", net_in_ack, 1);
    if (exact_lat >= 0) check("rx_ack_lat", n, exact_lat);
    repeat (hold) tick();
    check("rx_ack_hold", net_in_ack, 1);
    net_in_req = 1'b0;
    net_in_data = {3'($urandom), 32'($urandom)};
    n = 0;
    while (net_in_ack && n < 100) begin tick(); n++; end
    check("rx_ack_fall", net_in_ack, 0);
    if (exact_lat >= 0) check("rx_ack_fall_lat", n, SS + 1);
  endtask

  task automatic pe_pop();
    logic [34:0] e;
    check("rx_valid_pop", rx_valid, 1);
    if (rx_exp_q.size() == 0) begin
      check("rx_unexpected", rx_valid, 0);
    end else begin
      e = rx_exp_q.pop_front();
      check("rx_src", rx_src, e[30:27]);
      check("rx_type", rx_type, e[26:24]);
      check("rx_payload", rx_payload, e[23:0]);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic run_concurrent(input int unsigned n, input bit rand_mode);
    rx_done = 1'b0;
    fork
      begin
        for (int unsigned i = 0; i < n; i++) begin
          logic [3:0]  d;
          logic [2:0]  t;
          logic [23:0] p;
          d = 4'($urandom); t = 3'($urandom); p = 24'($urandom);
          tx_send(d, t, p, {d, NODE, t, p}, rand_mode ? $urandom_range(0, 3) : 0);
        end
      end
      begin
        for (int unsigned j = 0; j < n; j++) begin
          logic [3:0] d;
          d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : NODE;
          rx_start({d, 4'($urandom), 3'($urandom), 24'($urandom)});
          rx_finish(-1, rand_mode ? $urandom_range(0, 3) : 0);
        end
        rx_done = 1'b1;
      end
      begin
        int unsigned guard;
        logic [34:0] e;
        guard = 0;
        while ((!rx_done || rx_exp_q.size() != 0) && guard < 20000) begin
          rx_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) begin
              check("rx_duplicate", rx_valid, 0);
            end else begin
              e = rx_exp_q.pop_front();
              check("cc_rx_src", rx_src, e[30:27]);
              check("cc_rx_type", rx_type, e[26:24]);
              check("cc_rx_payload", rx_payload, e[23:0]);
            end
          end
          tick();
          guard++;
        end
        rx_ready = 1'b0;
        check("cc_rx_drained", rx_exp_q.size(), 0);
      end
    join
    check("cc_rx_empty", rx_valid, 0);
    check("cc_misroute", misroute_cnt, sat255(mis_exp));
  endtask

  initial begin
    tx_vecs[0] = '{4'h9, 3'h2, 24'hABCDEF, {4'h9, 4'h5, 3'h2, 24'hABCDEF}};
    tx_vecs[1] = '{4'h5, 3'h7, 24'hFFFFFF, {4'h5, 4'h5, 3'h7, 24'hFFFFFF}};
    tx_vecs[2] = '{4'h0, 3'h0, 24'h000000, {4'h0, 4'h5, 3'h0, 24'h000000}};
    tx_vecs[3] = '{4'hF, 3'h5, 24'h5A5A5A, {4'hF, 4'h5, 3'h5, 24'h5A5A5A}};

    reset = 1'b1; tx_valid = 1'b0; tx_dest = '0; tx_type = '0; tx_payload = '0;
    net_out_ack = 1'b0; net_in_req = 1'b0; net_in_data = '0; rx_ready = 1'b0;
    tick(); tick();
    check("rst_out_req", net_out_req, 0);
    check("rst_out_data", net_out_data, 0);
    check("rst_in_ack", net_in_ack, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_src", rx_src, 0);
    check("rst_rx_type", rx_type, 0);
    check("rst_rx_payload", rx_payload, 0);
    check("rst_misroute", misroute_cnt, 0);
    reset = 1'b0;

    for (int unsigned k = 0; k < 4; k++)
      tx_send(tx_vecs[k].dest, tx_vecs[k].ptype, tx_vecs[k].payload, tx_vecs[k].exp_data, k);

    // Reset while waiting for the router's ack.
    tx_dest = 4'h3; tx_type = 3'h1; tx_payload = 24'h123456; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    check("midtx_req_up", net_out_req, 1);
    tick();
    reset = 1'b1;
    tick();
    check("midtx_req_cleared", net_out_req, 0);
    check("midtx_ready_low", tx_ready, 0);
    check("midtx_data_cleared", net_out_data, 0);
    reset = 1'b0;
    tick();
    check("midtx_ready_back", tx_ready, 1);

    rx_start({4'h5, 4'h3, 3'h1, 24'h000123});
    rx_finish(SS + 1, 2);
    check("rx1_valid", rx_valid, 1);
    check("rx1_src", rx_src, 4'h3);
    check("rx1_type", rx_type, 3'h1);
    check("rx1_payload", rx_payload, 24'h000123);
    pe_pop();
    check("rx1_empty", rx_valid, 0);

    for (int unsigned k = 0; k < 4; k++) begin
      rx_start({NODE, 4'(k + 1), 3'(k), 24'(32'h100 + k)});
      rx_finish(SS + 1, 0);
    end
    check("full_valid", rx_valid, 1);
    rx_start({NODE, 4'hE, 3'h6, 24'hEEEEEE});
    repeat (10) tick();
    check("full_ack_withheld", net_in_ack, 0);
    pe_pop();
    rx_finish(-1, 0);
    repeat (4) pe_pop();
    check("full_drained", rx_valid, 0);

    rx_start({4'h7, 4'h3, 3'h4, 24'h777777});
    rx_finish(SS + 1, 0);
    check("mis_not_pushed", rx_valid, 0);
    check("mis_cnt_1", misroute_cnt, 8'd1);
    for (int unsigned k = 0; k < 299; k++) begin
      int unsigned d;
      d = $urandom_range(0, 14);
      if (d >= 5) d++;
      rx_start({4'(d), 4'($urandom), 3'($urandom), 24'($urandom)});
      rx_finish(-1, 0);
    end
    check("mis_cnt_sat", misroute_cnt, 8'd255);
    check("mis_no_push", rx_valid, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    mis_exp = 0;
    rx_exp_q.delete();
    run_concurrent(8, 1'b0);
    run_concurrent(40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
